// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit.
// Owns the architectural HI/LO registers. Executes MULT/MULTU/DIV/DIVU with a
// fixed multi-cycle latency, and handles MTHI/MTLO/MFHI/MFLO.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset; clears all state
//   op        4-bit opcode (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//             5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9..15 treated as NONE)
//   opValid   EX holds a real instruction carrying op
//   cancel    kernel entry in MEM this cycle; the EX instruction is flushed
//   srcA      rs operand (forwarded)
//   srcB      rt operand (forwarded)
//   stallReq  combinational stall request while an op is in flight
//   busy      registered, multiply/divide in flight
//   done      registered one-cycle pulse in the cycle after busy falls
//   hi, lo    architectural HI/LO registers
//   rdata     combinational MFHI/MFLO read data, 0 for other ops
module ex_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic        opValid,
    input  logic        cancel,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        stallReq,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;
    logic              res_wr;

    // Decoded request
    logic        accept;
    logic        is_mul;
    logic        is_div;
    logic        is_signed;
    logic        mdu_op;

    // Datapath for the operation being started
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_p;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic        div_zero;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] nxt_hi;
    logic [31:0] nxt_lo;
    logic        nxt_wr;

    // Opcode decode and pipeline handshake
    always_comb begin
        is_mul    = (op == OP_MULT) || (op == OP_MULTU);
        is_div    = (op == OP_DIV)  || (op == OP_DIVU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        mdu_op    = (op >= OP_MULT) && (op <= OP_MFLO);
        accept    = opValid && !cancel && !busy;
        stallReq  = opValid && mdu_op && busy;
    end

    // MFHI/MFLO read path
    always_comb begin
        rdata = 32'd0;
        if (op == OP_MFHI) begin
            rdata = hi;
        end else if (op == OP_MFLO) begin
            rdata = lo;
        end
    end

    // Product: sign- or zero-extend to 64 bits, so one multiplier serves both
    always_comb begin
        mul_a = {{32{is_signed & srcA[31]}}, srcA};
        mul_b = {{32{is_signed & srcB[31]}}, srcB};
        mul_p = mul_a * mul_b;
    end

    // Quotient/remainder: divide magnitudes, then restore signs
    // (quotient truncates toward zero, remainder follows the dividend).
    // A zero divisor is replaced by 1 to keep the divider well-defined;
    // its result is never committed.
    always_comb begin
        neg_a    = is_signed & srcA[31];
        neg_b    = is_signed & srcB[31];
        mag_a    = neg_a ? (32'd0 - srcA) : srcA;
        mag_b    = neg_b ? (32'd0 - srcB) : srcB;
        div_zero = (srcB == 32'd0);
        safe_b   = div_zero ? 32'd1 : mag_b;
        q_mag    = mag_a / safe_b;
        r_mag    = mag_a % safe_b;
        quo      = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem      = neg_a ? (32'd0 - r_mag) : r_mag;
    end

    // Result selection for the start edge
    always_comb begin
        nxt_hi = 32'd0;
        nxt_lo = 32'd0;
        nxt_wr = 1'b0;
        if (is_mul) begin
            nxt_hi = mul_p[63:32];
            nxt_lo = mul_p[31:0];
            nxt_wr = 1'b1;
        end else if (is_div) begin
            nxt_hi = rem;
            nxt_lo = quo;
            nxt_wr = !div_zero;
        end
    end

    // Control FSM, latency counter and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_wr <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul || is_div) begin
                            res_hi <= nxt_hi;
                            res_lo <= nxt_lo;
                            res_wr <= nxt_wr;
                            cnt    <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy   <= 1'b1;
                            state  <= S_BUSY;
                        end else if (op == OP_MTHI) begin
                            hi <= srcA;
                        end else if (op == OP_MTLO) begin
                            lo <= srcA;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        // Final busy cycle: commit (unless divide by zero)
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        res_wr <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed self-checking bench for ex_mdu.
// Inputs change #1 after each rising edge; outputs are checked at that point.
module tb_ex_mdu;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic        opValid;
    logic        cancel;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        stallReq;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int passed;
    int total;

    ex_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .opValid (opValid),
        .cancel  (cancel),
        .srcA    (srcA),
        .srcB    (srcB),
        .stallReq(stallReq),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op      = o;
        srcA    = a;
        srcB    = b;
        opValid = 1'b1;
    endtask

    task automatic idle();
        op      = 4'd0;
        opValid = 1'b0;
        cancel  = 1'b0;
    endtask

    // Start an op, then count busy cycles until busy falls (bounded)
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        drive(o, a, b);
        tick();
        idle();
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    initial begin
        int cyc;
        int n;
        passed  = 0;
        total   = 0;
        reset   = 1'b1;
        op      = 4'd0;
        opValid = 1'b0;
        cancel  = 1'b0;
        srcA    = 32'd0;
        srcB    = 32'd0;

        // Reset state; MFHI held during reset must neither stall nor read
        tick();
        tick();
        drive(4'd7, 32'd0, 32'd0);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stallReq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        idle();
        reset = 1'b0;
        tick();

        // MULT -2 * 3 = -6
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
        check("mult_cycles", 32'(cyc), 32'd5);
        check("mult_done", 32'(done), 32'd1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        tick();
        check("mult_done_pulse", 32'(done), 32'd0);

        // MULTU with MFHI presented the cycle after start
        drive(4'd2, 32'hFFFF_FFFE, 32'd3);
        tick();
        drive(4'd7, 32'd0, 32'd0);
        n = 0;
        while (stallReq && n < 100) begin
            n++;
            tick();
        end
        check("multu_stall", 32'(n), 32'd5);
        check("multu_rdata", rdata, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);
        idle();
        tick();

        // DIV -7 / 2
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
        check("div_cycles", 32'(cyc), 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // Overflow case
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        // MTHI/MTLO, then MFHI with no stall
        drive(4'd5, 32'h11, 32'd0);
        tick();
        check("mthi_busy", 32'(busy), 32'd0);
        drive(4'd7, 32'd0, 32'd0);
        #1;
        check("mfhi_nostall", 32'(stallReq), 32'd0);
        check("mfhi_rdata", rdata, 32'h11);
        drive(4'd6, 32'h22, 32'd0);
        tick();
        check("mtlo_lo", lo, 32'h22);

        // DIVU by zero keeps HI/LO but takes full latency
        run_op(4'd4, 32'd7, 32'd0, cyc);
        check("div0_cycles", 32'(cyc), 32'd10);
        check("div0_done", 32'(done), 32'd1);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        // Cancelled MULT and MTLO
        drive(4'd1, 32'd5, 32'd5);
        cancel = 1'b1;
        tick();
        idle();
        check("cancel_busy0", 32'(busy), 32'd0);
        tick();
        check("cancel_busy1", 32'(busy), 32'd0);
        check("cancel_hi", hi, 32'h11);
        check("cancel_lo", lo, 32'h22);
        drive(4'd6, 32'h1234, 32'd0);
        cancel = 1'b1;
        tick();
        idle();
        check("cancel_mtlo", lo, 32'h22);

        // Reset during busy cycle 4 discards the DIV
        drive(4'd3, 32'd100, 32'd7);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) n++;
            tick();
        end
        check("midrst_no_done", 32'(n), 32'd0);

        // DIVU 100/7
        run_op(4'd4, 32'd100, 32'd7, cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // Back-to-back: DIVU held under stall, starts in the done cycle
        drive(4'd1, 32'd3, 32'd4);
        tick();
        drive(4'd4, 32'd9, 32'd2);
        n = 0;
        while (stallReq && n < 100) begin
            n++;
            tick();
        end
        check("b2b_stall", 32'(n), 32'd5);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_mult_lo", lo, 32'd12);
        check("b2b_mult_hi", hi, 32'd0);
        tick();
        idle();
        check("b2b_busy", 32'(busy), 32'd1);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        check("b2b_div_cycles", 32'(cyc), 32'd10);
        check("b2b_div_lo", lo, 32'd4);
        check("b2b_div_hi", hi, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
